disp_sched: RTL and testbench

DISP_SCHED -- requirements
Module: disp_sched

---
 rtl/disp_sched_pkg.sv | 29 ++
 rtl/disp_sched_blink_gen.sv | 28 ++
 rtl/disp_sched.sv | 129 ++++++++++++
 tb/tb_disp_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_sched_pkg.sv
// Shared display definitions: scheduler states, requester indices, display widths
// and the fixed-priority pick used on every grant.
package disp_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN    = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   localparam int NUM_REQ = 3;
   localparam int REQ_CLK = 0;
   localparam int REQ_SET = 1;
   localparam int REQ_ALM = 2;

   localparam int DIGITS = 6;
   localparam int DIG_W  = 7;
   localparam int SEG_W  = DIGITS * DIG_W;
   localparam int DP_W   = DIGITS;

   // Fixed priority, alarm first: one-hot of the highest set request.
   function automatic logic [NUM_REQ-1:0] pick_hi(input logic [NUM_REQ-1:0] req);
      pick_hi = '0;
      if (req[REQ_ALM])      pick_hi[REQ_ALM] = 1'b1;
      else if (req[REQ_SET]) pick_hi[REQ_SET] = 1'b1;
      else if (req[REQ_CLK]) pick_hi[REQ_CLK] = 1'b1;
   endfunction

endpackage

// File: rtl/disp_sched_blink_gen.sv
// Free-running blink timebase: counts 0..BLINK_CYC-1 and flips the phase on each wrap.
// phase_nxt lets the owner's registered outputs line up with the phase they are shown in.
module blink_gen #(
   parameter logic [31:0] BLINK_CYC = 32'd25000000
) (
   input  logic clk,
   input  logic rst,
   output logic phase,
   output logic phase_nxt
);

   logic [31:0] cnt;
   logic        wrap;

   assign wrap      = (cnt == BLINK_CYC - 32'd1);
   assign phase_nxt = phase ^ wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         cnt   <= wrap ? '0 : cnt + 32'd1;
         phase <= phase_nxt;
      end
   end

endmodule

// File: rtl/disp_sched.sv
// Display ownership scheduler: arbitrates clock/setup/alarm for the six-digit display
// with minimum hold, alarm preemption and a one-cycle blanked handover.
module disp_sched
   import disp_sched_pkg::*;
#(
   parameter logic [31:0] HOLD_CYC  = 32'd5000000,
   parameter logic [31:0] BLINK_CYC = 32'd25000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [NUM_REQ*SEG_W-1:0]   i_seg,
   input  logic [NUM_REQ*DP_W-1:0]    i_dp,
   input  logic [NUM_REQ*DP_W-1:0]    i_blink_mask,
   output logic [NUM_REQ-1:0]         o_grant,
   output logic [SEG_W-1:0]           o_six_digit_seg,
   output logic [DP_W-1:0]            o_six_dp,
   output logic                       o_blink_phase
);

   state_t               state, state_d;
   logic [NUM_REQ-1:0]   grant_d;
   logic [31:0]          hold, hold_d;
   logic                 req_seen;
   logic                 phase_nxt;

   logic [SEG_W-1:0]     own_seg;
   logic [DP_W-1:0]      own_dp, own_mask;
   logic                 own_req;
   logic                 hold_done;
   logic                 keep;
   logic [SEG_W-1:0]     seg_d;
   logic [DP_W-1:0]      dp_d;

   blink_gen #(.BLINK_CYC(BLINK_CYC)) u_blink (
      .clk       (clk),
      .rst       (rst),
      .phase     (o_blink_phase),
      .phase_nxt (phase_nxt)
   );

   // Current owner's slices, selected by the registered one-hot grant.
   always_comb begin
      own_seg  = '0;
      own_dp   = '0;
      own_mask = '0;
      own_req  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (o_grant[i]) begin
            own_seg  = i_seg[i*SEG_W +: SEG_W];
            own_dp   = i_dp[i*DP_W +: DP_W];
            own_mask = i_blink_mask[i*DP_W +: DP_W];
            own_req  = i_req[i];
         end
      end
   end

   assign hold_done = (hold == HOLD_CYC - 32'd1);

   always_comb begin
      state_d = state;
      grant_d = o_grant;
      hold_d  = hold;
      unique case (state)
         ST_IDLE: begin
            // req_seen delays the first grant after reset by one requesting edge.
            if (req_seen && (|i_req)) begin
               state_d = ST_OWN;
               grant_d = pick_hi(i_req);
               hold_d  = '0;
            end
         end
         ST_OWN: begin
            if (!own_req ||
                (i_req[REQ_ALM] && !o_grant[REQ_ALM]) ||
                (o_grant[REQ_CLK] && i_req[REQ_SET] && hold_done)) begin
               state_d = ST_SWITCH;
               grant_d = '0;
               hold_d  = '0;
            end else if (!hold_done) begin
               hold_d = hold + 32'd1;
            end
         end
         ST_SWITCH: begin
            grant_d = pick_hi(i_req);
            hold_d  = '0;
            state_d = (|i_req) ? ST_OWN : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            hold_d  = '0;
         end
      endcase
   end

   // Data only flows while the same owner stays; entry and handover cycles show blank.
   assign keep = (state == ST_OWN) && (state_d == ST_OWN);

   always_comb begin
      seg_d = '0;
      dp_d  = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (keep && !(own_mask[d] && phase_nxt)) begin
            seg_d[d*DIG_W +: DIG_W] = own_seg[d*DIG_W +: DIG_W];
            dp_d[d]                 = own_dp[d];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         o_grant         <= '0;
         hold            <= '0;
         req_seen        <= 1'b0;
         o_six_digit_seg <= '0;
         o_six_dp        <= '0;
      end else begin
         state           <= state_d;
         o_grant         <= grant_d;
         hold            <= hold_d;
         req_seen        <= req_seen | (|i_req);
         o_six_digit_seg <= seg_d;
         o_six_dp        <= dp_d;
      end
   end

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched (HOLD_CYC=4, BLINK_CYC=8): directed scenarios
// plus randomized traffic against an owner/edge-count reference model.
module tb_disp_sched;

   localparam int HOLD  = 4;
   localparam int BLINK = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [2:0]   i_req = '0;
   logic [125:0] i_seg = '0;
   logic [17:0]  i_dp = '0;
   logic [17:0]  i_blink_mask = '0;
   logic [2:0]   o_grant;
   logic [41:0]  o_six_digit_seg;
   logic [5:0]   o_six_dp;
   logic         o_blink_phase;

   int checks = 0;
   int failures = 0;

   // Reference model: owner index (-1 = none), handover flag, edges since reset.
   int   owner = -1;
   bit   sw = 1'b0;
   int   hold = 0;
   bit   armed = 1'b0;
   int   edges = 0;
   logic [2:0]  exp_grant = '0;
   logic [41:0] exp_seg = '0;
   logic [5:0]  exp_dp = '0;
   logic        exp_phase = 1'b0;

   disp_sched #(.HOLD_CYC(32'd4), .BLINK_CYC(32'd8)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_req           (i_req),
      .i_seg           (i_seg),
      .i_dp            (i_dp),
      .i_blink_mask    (i_blink_mask),
      .o_grant         (o_grant),
      .o_six_digit_seg (o_six_digit_seg),
      .o_six_dp        (o_six_dp),
      .o_blink_phase   (o_blink_phase)
   );

   always #5 clk = ~clk;

   function automatic int hi(input logic [2:0] r);
      if (r[2]) return 2;
      if (r[1]) return 1;
      if (r[0]) return 0;
      return -1;
   endfunction

   task automatic model_reset();
      owner = -1; sw = 1'b0; hold = 0; armed = 1'b0; edges = 0;
      exp_grant = '0; exp_seg = '0; exp_dp = '0; exp_phase = 1'b0;
   endtask

   task automatic model_edge();
      int prev;
      prev = owner;
      edges++;
      if (sw) begin
         sw = 1'b0; owner = hi(i_req); hold = 0;
      end else if (owner < 0) begin
         if (armed && i_req != 3'b000) begin owner = hi(i_req); hold = 0; end
      end else if (!i_req[owner] || (i_req[2] && owner != 2) ||
                   (owner == 0 && i_req[1] && hold == HOLD - 1)) begin
         owner = -1; sw = 1'b1;
      end else if (hold < HOLD - 1) begin
         hold++;
      end
      if (i_req != 3'b000) armed = 1'b1;
      exp_phase = ((edges / BLINK) % 2) != 0;
      exp_grant = (owner >= 0) ? 3'(1 << owner) : 3'b000;
      exp_seg = '0;
      exp_dp  = '0;
      if (prev >= 0 && owner == prev) begin
         for (int d = 0; d < 6; d++) begin
            if (!(i_blink_mask[prev*6+d] && exp_phase)) begin
               exp_seg[d*7 +: 7] = i_seg[prev*42 + d*7 +: 7];
               exp_dp[d]         = i_dp[prev*6 + d];
            end
         end
      end
   endtask

   // Drive at the falling edge, advance one rising edge, return at the next falling edge.
   task automatic step(input logic [2:0] r);
      i_req = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      i_req = 3'b111;
      i_seg = {42'h3FF_FFFF_FFFF, 42'h155_5555_5555, 42'h0AA_AAAA_AAAA};
      i_dp  = '1;
      repeat (3) @(negedge clk);
      checks++; if (o_grant !== 3'b000) begin failures++; $display("FAIL rst_grant got=%b exp=000", o_grant); end
      checks++; if (o_six_digit_seg !== 42'd0) begin failures++; $display("FAIL rst_seg got=%h exp=0", o_six_digit_seg); end
      checks++; if (o_six_dp !== 6'd0) begin failures++; $display("FAIL rst_dp got=%b exp=0", o_six_dp); end
      checks++; if (o_blink_phase !== 1'b0) begin failures++; $display("FAIL rst_phase got=%b exp=0", o_blink_phase); end
      i_req = 3'b000;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_grant_latency();
      logic [41:0] s0;
      i_blink_mask = '0;
      step(3'b001);
      checks++; if (o_grant !== 3'b000) begin failures++; $display("FAIL first_edge_grant got=%b exp=000", o_grant); end
      step(3'b001);
      checks++; if (o_grant !== 3'b001) begin failures++; $display("FAIL idle_grant got=%b exp=001", o_grant); end
      checks++; if (o_six_digit_seg !== 42'd0) begin failures++; $display("FAIL entry_seg got=%h exp=0", o_six_digit_seg); end
      s0 = i_seg[41:0];
      step(3'b001);
      checks++; if (o_six_digit_seg !== s0) begin failures++; $display("FAIL own_seg got=%h exp=%h", o_six_digit_seg, s0); end
   endtask

   task automatic test_hold();
      step(3'b000); step(3'b000);   // owner drop -> handover -> idle
      step(3'b001); step(3'b001);   // grant req0, hold now 1
      step(3'b011);
      checks++; if (o_grant !== 3'b001) begin failures++; $display("FAIL hold_h2 got=%b exp=001", o_grant); end
      step(3'b011);
      checks++; if (o_grant !== 3'b001) begin failures++; $display("FAIL hold_h3 got=%b exp=001", o_grant); end
      step(3'b011);
      checks++; if (o_grant !== 3'b000) begin failures++; $display("FAIL hold_switch_grant got=%b exp=000", o_grant); end
      checks++; if (o_six_digit_seg !== 42'd0 || o_six_dp !== 6'd0) begin failures++; $display("FAIL hold_switch_out got=%h/%b exp=0/0", o_six_digit_seg, o_six_dp); end
      step(3'b011);
      checks++; if (o_grant !== 3'b010) begin failures++; $display("FAIL hold_regrant got=%b exp=010", o_grant); end
   endtask

   task automatic test_preempt();
      step(3'b110);
      checks++; if (o_grant !== 3'b000) begin failures++; $display("FAIL alarm_switch got=%b exp=000", o_grant); end
      step(3'b110);
      checks++; if (o_grant !== 3'b100) begin failures++; $display("FAIL alarm_grant got=%b exp=100", o_grant); end
   endtask

   task automatic test_drop();
      step(3'b010);
      checks++; if (o_grant !== 3'b000) begin failures++; $display("FAIL drop2_switch got=%b exp=000", o_grant); end
      step(3'b010);
      checks++; if (o_grant !== 3'b010) begin failures++; $display("FAIL drop2_grant got=%b exp=010", o_grant); end
      for (int k = 0; k < 6; k++) begin
         step(3'b011);
         checks++; if (o_grant !== 3'b010) begin failures++; $display("FAIL low_no_preempt k=%0d got=%b exp=010", k, o_grant); end
      end
      step(3'b001);
      checks++; if (o_grant !== 3'b000) begin failures++; $display("FAIL drop1_switch got=%b exp=000", o_grant); end
      step(3'b001);
      checks++; if (o_grant !== 3'b001) begin failures++; $display("FAIL drop1_grant got=%b exp=001", o_grant); end
   endtask

   task automatic test_blink();
      int   toggles;
      logic last;
      logic [13:0] lo_exp;
      logic [27:0] hi_ones;
      hi_ones = '1;
      i_seg = '1;
      i_dp  = '1;
      i_blink_mask = {12'd0, 6'b000011};
      toggles = 0;
      last = o_blink_phase;
      for (int k = 0; k < 32; k++) begin
         step(3'b001);
         lo_exp = exp_phase ? 14'd0 : 14'h3FFF;
         if (o_blink_phase !== last) toggles++;
         last = o_blink_phase;
         checks++; if (o_six_digit_seg[13:0] !== lo_exp) begin failures++; $display("FAIL blink_lo k=%0d got=%h exp=%h", k, o_six_digit_seg[13:0], lo_exp); end
         checks++; if (o_six_digit_seg[41:14] !== hi_ones) begin failures++; $display("FAIL blink_hi k=%0d got=%h exp=%h", k, o_six_digit_seg[41:14], hi_ones); end
         checks++; if (o_six_dp !== (exp_phase ? 6'b111100 : 6'b111111)) begin failures++; $display("FAIL blink_dp k=%0d got=%b phase=%b", k, o_six_dp, exp_phase); end
      end
      checks++; if (toggles != 4) begin failures++; $display("FAIL blink_toggles got=%0d exp=4", toggles); end
   endtask

   task automatic test_random();
      logic [127:0] t;
      logic [2:0]   r;
      r = 3'b001;
      for (int n = 0; n < 500; n++) begin
         t = {$urandom(), $urandom(), $urandom(), $urandom()};
         i_seg = t[125:0];
         i_dp = 18'($urandom());
         i_blink_mask = 18'($urandom());
         if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
         step(r);
         checks++; if (o_grant !== exp_grant) begin failures++; $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, o_grant, exp_grant); end
         checks++; if (o_six_digit_seg !== exp_seg) begin failures++; $display("FAIL rnd_seg n=%0d got=%h exp=%h", n, o_six_digit_seg, exp_seg); end
         checks++; if (o_six_dp !== exp_dp) begin failures++; $display("FAIL rnd_dp n=%0d got=%b exp=%b", n, o_six_dp, exp_dp); end
         checks++; if (o_blink_phase !== exp_phase) begin failures++; $display("FAIL rnd_phase n=%0d got=%b exp=%b", n, o_blink_phase, exp_phase); end
         checks++; if (!$onehot0(o_grant)) begin failures++; $display("FAIL rnd_onehot n=%0d got=%b exp=onehot0", n, o_grant); end
      end
   endtask

   task automatic test_async_reset();
      i_seg = '1; i_dp = '1; i_blink_mask = '0;
      repeat (4) step(3'b100);
      checks++; if (o_grant !== 3'b100 || o_six_digit_seg !== exp_seg) begin failures++; $display("FAIL pre_rst got=%b/%h exp=100/%h", o_grant, o_six_digit_seg, exp_seg); end
      #2 rst = 1'b1;
      #1;
      checks++; if (o_grant !== 3'b000) begin failures++; $display("FAIL arst_grant got=%b exp=000", o_grant); end
      checks++; if (o_six_digit_seg !== 42'd0 || o_six_dp !== 6'd0) begin failures++; $display("FAIL arst_out got=%h/%b exp=0/0", o_six_digit_seg, o_six_dp); end
      checks++; if (o_blink_phase !== 1'b0) begin failures++; $display("FAIL arst_phase got=%b exp=0", o_blink_phase); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(3'b100);
      checks++; if (o_grant !== 3'b000) begin failures++; $display("FAIL arst_first_edge got=%b exp=000", o_grant); end
      step(3'b100);
      checks++; if (o_grant !== 3'b100) begin failures++; $display("FAIL arst_regrant got=%b exp=100", o_grant); end
   endtask

   initial begin
      test_reset();
      test_grant_latency();
      test_hold();
      test_preempt();
      test_drop();
      test_blink();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
